clk_div_bank: RTL and testbench

CLK_DIV_BANK -- requirements
Module: clk_div_bank

---
 rtl/clk_div_bank.sv | 137 +++++++++++++
 tb/tb_clk_div_bank.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of NCH independent 50%-duty clock dividers on CLK_40M.
// Each channel toggles clk_out after N cycles (period 2N). A newly loaded
// ratio waits for the end of the current period (the 1->0 toggle), so no
// short or stretched pulse appears when the ratio changes.
// Optional feature macro: CLKDIV_STB_EN. When defined, stb pulses on each
// rising edge of clk_out. When undefined, stb is tied low and has no flops.
module clk_div_bank #(
    parameter int                  NCH      = 3,
    parameter int                  CW       = 5,
    parameter logic [NCH*CW-1:0]   DIV_INIT = {5'd8, 5'd4, 5'd2}
) (
    input  logic                CLK_40M,
    input  logic                rst_n,
    input  logic [NCH-1:0]      ch_en,
    input  logic [NCH*CW-1:0]   div_ratio,
    input  logic                load,
    input  logic                sync_clr,
    output logic [NCH-1:0]      clk_out,
    output logic [NCH-1:0]      stb,
    output logic [NCH-1:0]      pend
);

    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];
    logic [CW-1:0]  act_q [NCH];
    logic [CW-1:0]  act_d [NCH];
    logic [CW-1:0]  pnd_q [NCH];
    logic [CW-1:0]  pnd_d [NCH];
    logic [NCH-1:0] clk_q, clk_d;
    logic [NCH-1:0] pend_q, pend_d;

    // Per-channel scratch values, recomputed for every channel in the loop.
    logic           run_c;
    logic           wrap_c;
    logic           fall_c;
    logic [CW-1:0]  req_c;

    // Next-state for counters, divided clocks and the active/pending ratios.
    always_comb begin
        run_c  = 1'b0;
        wrap_c = 1'b0;
        fall_c = 1'b0;
        req_c  = '0;
        clk_d  = clk_q;
        pend_d = pend_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            act_d[i] = act_q[i];
            pnd_d[i] = pnd_q[i];

            req_c  = div_ratio[i*CW +: CW];
            run_c  = ch_en[i] && (act_q[i] != '0);
            wrap_c = (cnt_q[i] == (act_q[i] - ONE));
            // Period boundary: the toggle that takes clk_out from 1 to 0.
            fall_c = run_c && !sync_clr && wrap_c && clk_q[i];

            // Disable beats sync_clr, which beats normal counting.
            if (!ch_en[i] || sync_clr || (act_q[i] == '0)) begin
                cnt_d[i] = '0;
                clk_d[i] = 1'b0;
            end else if (wrap_c) begin
                cnt_d[i] = '0;
                clk_d[i] = ~clk_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + ONE;
            end

            // A fresh load always refreshes the holding register; later
            // loads simply overwrite it.
            if (load) begin
                pnd_d[i] = req_c;
            end

            // A ratio may take effect when the channel is realigned, idle,
            // or at a period boundary; the newest request wins.
            if (sync_clr || !run_c || fall_c) begin
                if (load) begin
                    act_d[i] = req_c;
                end else if (pend_q[i]) begin
                    act_d[i] = pnd_q[i];
                end
                pend_d[i] = 1'b0;
            end else if (load) begin
                pend_d[i] = 1'b1;
            end
        end
    end

    // State registers; reset restores the power-up ratios and drops pending ones.
    always_ff @(posedge CLK_40M or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
                act_q[i] <= DIV_INIT[i*CW +: CW];
                pnd_q[i] <= '0;
            end
            clk_q  <= '0;
            pend_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
                act_q[i] <= act_d[i];
                pnd_q[i] <= pnd_d[i];
            end
            clk_q  <= clk_d;
            pend_q <= pend_d;
        end
    end

    assign clk_out = clk_q;
    assign pend    = pend_q;

`ifdef CLKDIV_STB_EN
    logic [NCH-1:0] stb_q, stb_d;

    // Strobe is registered alongside clk_out so it is high in its first high cycle.
    always_comb begin
        stb_d = clk_d & ~clk_q;
    end

    // Strobe register.
    always_ff @(posedge CLK_40M or negedge rst_n) begin
        if (!rst_n) begin
            stb_q <= '0;
        end else begin
            stb_q <= stb_d;
        end
    end

    assign stb = stb_q;
`else
    assign stb = '0;
`endif

endmodule

// File: tb/tb_clk_div_bank.sv
// Testbench for clk_div_bank: directed scenarios followed by random traffic,
// all compared cycle by cycle against a phase-based reference model.
module tb_clk_div_bank;

    localparam int NCH = 3;
    localparam int CW  = 5;
`ifdef CLKDIV_STB_EN
    localparam bit STB_ON = 1'b1;
`else
    localparam bit STB_ON = 1'b0;
`endif

    logic                CLK_40M;
    logic                rst_n;
    logic [NCH-1:0]      ch_en;
    logic [NCH*CW-1:0]   div_ratio;
    logic                load;
    logic                sync_clr;
    logic [NCH-1:0]      clk_out;
    logic [NCH-1:0]      stb;
    logic [NCH-1:0]      pend;

    int errors = 0;
    int checks = 0;

    // Reference model: each channel is described by its phase t within the
    // current 2N-cycle period; clk_out is high for t in [N, 2N).
    int m_t   [NCH];
    int m_n   [NCH];
    int m_pn  [NCH];
    bit m_pend[NCH];
    bit m_clk [NCH];
    bit m_stb [NCH];

    clk_div_bank dut (
        .CLK_40M   (CLK_40M),
        .rst_n     (rst_n),
        .ch_en     (ch_en),
        .div_ratio (div_ratio),
        .load      (load),
        .sync_clr  (sync_clr),
        .clk_out   (clk_out),
        .stb       (stb),
        .pend      (pend)
    );

    initial begin
        CLK_40M = 1'b0;
        forever #5 CLK_40M = ~CLK_40M;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_n[0] = 2; m_n[1] = 4; m_n[2] = 8;
        for (int i = 0; i < NCH; i++) begin
            m_t[i] = 0; m_pn[i] = 0; m_pend[i] = 0; m_clk[i] = 0; m_stb[i] = 0;
        end
    endtask

    // One rising edge of the reference model, from the inputs seen at that edge.
    task automatic model_update();
        for (int i = 0; i < NCH; i++) begin
            int nt;
            int dr;
            bit nclk;
            bit fall;
            bit running;
            dr      = int'(div_ratio[i*CW +: CW]);
            running = ch_en[i] && (m_n[i] != 0);
            nt = 0; nclk = 0; fall = 0;
            if (running && !sync_clr) begin
                nt = m_t[i] + 1;
                if (nt == 2 * m_n[i]) begin
                    nt = 0;
                    fall = 1;
                end
                nclk = (nt >= m_n[i]);
            end
            m_stb[i] = nclk && !m_clk[i];
            if (sync_clr || !running || fall) begin
                if (load) m_n[i] = dr;
                else if (m_pend[i]) m_n[i] = m_pn[i];
                m_pend[i] = 0;
            end else if (load) begin
                m_pend[i] = 1;
            end
            if (load) m_pn[i] = dr;
            m_t[i]   = nt;
            m_clk[i] = nclk;
        end
    endtask

    function automatic logic [31:0] exp_clk();
        logic [31:0] v = '0;
        for (int i = 0; i < NCH; i++) v[i] = m_clk[i];
        return v;
    endfunction

    function automatic logic [31:0] exp_pend();
        logic [31:0] v = '0;
        for (int i = 0; i < NCH; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic logic [31:0] exp_stb();
        logic [31:0] v = '0;
        for (int i = 0; i < NCH; i++) v[i] = m_stb[i] && STB_ON;
        return v;
    endfunction

    // Advance one clock, update the model and compare all outputs after the edge.
    task automatic step();
        @(posedge CLK_40M);
        model_update();
        #1;
        chk("clk_out", 32'(clk_out), exp_clk());
        chk("pend",    32'(pend),    exp_pend());
        chk("stb",     32'(stb),     exp_stb());
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int found;
        rst_n     = 1'b0;
        ch_en     = 3'b111;
        div_ratio = '0;
        load      = 1'b0;
        sync_clr  = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(posedge CLK_40M);
        #1;
        chk("rst_clk",  32'(clk_out), 32'h0);
        chk("rst_pend", 32'(pend),    32'h0);
        chk("rst_stb",  32'(stb),     32'h0);

        // Default ratios: first rises at edges 2/4/8, periods 4/8/16
        @(negedge CLK_40M);
        rst_n = 1'b1;
        step();
        chk("dflt_e1", 32'(clk_out), 32'h0);
        step();
        chk("dflt_e2", 32'(clk_out), 32'h1);
        chk("dflt_stb_e2", 32'(stb), STB_ON ? 32'h1 : 32'h0);
        steps(2);
        chk("dflt_e4", 32'(clk_out), 32'h2);
        steps(4);
        chk("dflt_e8", 32'(clk_out), 32'h4);
        chk("dflt_stb_e8", 32'(stb), STB_ON ? 32'h4 : 32'h0);
        steps(24);

        // Reset mid-operation discards pending ratios
        div_ratio = {5'd3, 5'd3, 5'd3};
        load = 1'b1;
        step();
        load = 1'b0;
        chk("pre_rst_pend", 32'(pend), 32'h7);
        rst_n = 1'b0;
        #2;
        chk("async_rst_pend", 32'(pend),    32'h0);
        chk("async_rst_clk",  32'(clk_out), 32'h0);
        model_reset();
        @(negedge CLK_40M);
        rst_n = 1'b1;

        // Channel 0: N=2 -> N=5 loaded during the high phase
        steps(2);
        div_ratio = {5'd8, 5'd4, 5'd5};
        load = 1'b1;
        step();
        load = 1'b0;
        chk("ratio_pend_e3", 32'(pend), 32'h7);
        step();
        chk("ratio_pend_e4", 32'(pend), 32'h6);
        chk("ratio_clk0_e4", 32'(clk_out[0]), 32'h0);
        steps(4);
        chk("ratio_clk0_e8", 32'(clk_out[0]), 32'h0);
        step();
        chk("ratio_clk0_e9", 32'(clk_out[0]), 32'h1);
        steps(4);
        chk("ratio_clk0_e13", 32'(clk_out[0]), 32'h1);
        step();
        chk("ratio_clk0_e14", 32'(clk_out[0]), 32'h0);
        steps(20);

        // Channel 1 disabled while high, then re-enabled
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            step();
            if (clk_out[1] === 1'b1) found = 1;
        end
        chk("wait_clk1_high", 32'(found), 32'h1);
        ch_en = 3'b101;
        step();
        chk("dis_clk1", 32'(clk_out[1]), 32'h0);
        steps(3);
        ch_en = 3'b111;
        steps(3);
        chk("reen_clk1_e3", 32'(clk_out[1]), 32'h0);
        step();
        chk("reen_clk1_e4", 32'(clk_out[1]), 32'h1);

        // sync_clr together with load applies ratios straight away
        div_ratio = {5'd6, 5'd4, 5'd3};
        load = 1'b1;
        sync_clr = 1'b1;
        step();
        load = 1'b0;
        sync_clr = 1'b0;
        chk("sync_load_clk",  32'(clk_out), 32'h0);
        chk("sync_load_pend", 32'(pend),    32'h0);
        steps(17);
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        chk("sync_clk", 32'(clk_out), 32'h0);
        steps(3);
        chk("sync_e3", 32'(clk_out), 32'h1);
        step();
        chk("sync_e4", 32'(clk_out), 32'h3);
        steps(2);
        chk("sync_e6", 32'(clk_out), 32'h6);

        // Channel 2: N=0 stops it at the boundary, N=1 then loads directly
        div_ratio = {5'd0, 5'd4, 5'd3};
        load = 1'b1;
        step();
        load = 1'b0;
        found = 0;
        for (int k = 0; k < 30 && found == 0; k++) begin
            step();
            if (pend[2] === 1'b0) found = 1;
        end
        chk("wait_pend2_clear", 32'(found), 32'h1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("n0_clk2", 32'(clk_out[2]), 32'h0);
        end
        div_ratio = {5'd1, 5'd4, 5'd3};
        load = 1'b1;
        step();
        load = 1'b0;
        chk("n1_pend2", 32'(pend[2]), 32'h0);
        step();
        chk("n1_clk2_a", 32'(clk_out[2]), 32'h1);
        step();
        chk("n1_clk2_b", 32'(clk_out[2]), 32'h0);
        step();
        chk("n1_clk2_c", 32'(clk_out[2]), 32'h1);

        // Random traffic against the model
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < NCH; i++) begin
                ch_en[i] = ($urandom_range(0, 7) != 0);
                div_ratio[i*CW +: CW] = CW'($urandom_range(0, 7));
            end
            load     = ($urandom_range(0, 19) == 0);
            sync_clr = ($urandom_range(0, 39) == 0);
            step();
        end
        load = 1'b0;
        sync_clr = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
